mips_fetch_decode: RTL and testbench
====================================

// Module: mips_fetch_decode
// PURPOSE
//  Multi-cycle instruction fetch/decode front end for the MIPS core: owns the PC,
//  issues requests to a variable-latency instruction memory, latches the returned
//  word and presents registered main-control signals to the datapath.
//  Adds a real PC, a memory handshake, stall and branch redirect.
// PARAMETERS
//  ADDR_W    32  PC / instruction-memory address width (bits)
//  DATA_W    32  instruction word width; opcode is DATA_W-1 : DATA_W-6
//  RESET_PC  0   PC value loaded on reset (word aligned)
//  PC_STEP   4   PC increment per fetched instruction
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  imem_req     out  1       fetch request, one-cycle pulse
//  imem_addr    out  ADDR_W  fetch address (= PC register)
//  imem_valid   in   1       read data valid, >=1 cycle after imem_req
//  imem_rdata   in   DATA_W  instruction word
//  stall        in   1       downstream not ready; hold current decode
//  redirect     in   1       branch/jump taken
//  redirect_pc  in   ADDR_W  new PC; bits [1:0] forced to 0
//  dec_valid    out  1       decode outputs valid
//  dec_pc       out  ADDR_W  address of decoded instruction
//  dec_instr    out  DATA_W  decoded instruction word
//  branch_eq, branch_ne, memread, memwrite, memtoreg, regdst, regwrite, alusrc
//               out  1 each  main-control signals
//  aluop        out  2       ALU operation class
//  illegal      out  1       unsupported opcode
// BEHAVIOUR
//  Reset (async, rst_n=0): state=REQ, PC=RESET_PC, drop=0; all outputs 0
//   except imem_addr=RESET_PC; imem_req first asserts in the cycle after release.
//  FSM (registered): REQ -> WAIT -> OUT -> REQ.
//   REQ : imem_req=1, imem_addr=PC for exactly one cycle; -> WAIT.
//   WAIT: on imem_valid: latch rdata into IR, dec_pc<=PC, PC<=PC+PC_STEP
//         (wraps mod 2^ADDR_W), controls latched from decoder; -> OUT.
//   OUT : dec_valid=1; stall=1 holds all outputs; stall=0 -> REQ.
//  Latency: imem_req at cycle 0, imem_valid at cycle k, dec_valid at k+1.
//   Min issue rate: one instruction per 3 cycles.
//  Redirect (any state, wins over stall): PC<=redirect_pc & ~3 next edge.
//   In REQ or WAIT: set drop; the pending response is discarded (no dec_valid),
//   PC unchanged by the discarded fetch; then -> REQ. In OUT: dec_valid=0 next
//   cycle, -> REQ. Redirect and imem_valid same cycle in WAIT: data discarded.
//  imem_valid outside WAIT is ignored.
//  Decode table (opcode -> regdst,alusrc,memtoreg,regwrite,memread,memwrite,
//   branch_eq,branch_ne,aluop):
//   000000 R  : 1,0,0,1,0,0,0,0,10    100011 lw : 0,1,1,1,1,0,0,0,00
//   101011 sw : 0,1,0,0,0,1,0,0,00    000100 beq: 0,0,0,0,0,0,1,0,01
//   000101 bne: 0,0,0,0,0,0,0,1,01    001000 addi:0,1,0,1,0,0,0,0,00
//   other     : all 0, illegal=1 (still presented with dec_valid).
//  Reset mid-operation: immediate return to reset values; in-flight fetch lost.
// STRUCTURE
//  Package mips_pkg: opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
//   OP_BNE, OP_ADDI), ALUOP_* codes, fsm state enum.
//  Sub-module mips_ctrl_decode: purely combinational opcode -> control table;
//   the top registers its outputs in the WAIT->OUT transition.
// TESTING
//  Reset, mem latency 1, rdata=0x8C220004 (lw) -> imem_req cycle 1, addr 0;
//   dec_valid cycle 3, memread=memtoreg=regwrite=alusrc=1, aluop=00, PC=4.
//  Latency 5, R-type 0x00221820 -> dec_valid exactly 1 cycle after imem_valid;
//   regdst=regwrite=1, aluop=10.
//  stall=1 for 4 cycles during OUT -> outputs stable, no imem_req; next req addr=4.
//  redirect=1, redirect_pc=0x103 in WAIT, valid next cycle -> no dec_valid;
//   next imem_addr=0x100.
//  opcode 111111 -> dec_valid=1, illegal=1, all controls 0; PC=0xFFFFFFFC
//   fetch -> PC wraps to 0.
//  rst_n low while in WAIT -> outputs 0 at once; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch/decode front end:
// opcodes, ALU operation classes, fetch FSM states and the control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_OUT
  } fetch_state_e;

  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch_eq;
    logic       branch_ne;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Purely combinational main-control decoder: opcode -> datapath control bundle.
// Opcodes outside the supported set produce an all-zero bundle with illegal set.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] i_opcode,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = CTRL_NONE;
    case (i_opcode)
      OP_RTYPE: begin
        o_ctrl.regdst   = 1'b1;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.aluop    = ALUOP_FUNCT;
      end
      OP_LW: begin
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.memtoreg = 1'b1;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.memread  = 1'b1;
        o_ctrl.aluop    = ALUOP_ADD;
      end
      OP_SW: begin
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.memwrite = 1'b1;
        o_ctrl.aluop    = ALUOP_ADD;
      end
      OP_BEQ: begin
        o_ctrl.branch_eq = 1'b1;
        o_ctrl.aluop     = ALUOP_SUB;
      end
      OP_BNE: begin
        o_ctrl.branch_ne = 1'b1;
        o_ctrl.aluop     = ALUOP_SUB;
      end
      OP_ADDI: begin
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.aluop    = ALUOP_ADD;
      end
      default: o_ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_fetch_decode.sv
// Multi-cycle fetch/decode front end: owns the PC, handshakes with a variable-latency
// instruction memory, latches the returned word and presents registered controls.
module mips_fetch_decode
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_valid,
  input  logic [DATA_W-1:0] i_imem_rdata,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_dec_valid,
  output logic [ADDR_W-1:0] o_dec_pc,
  output logic [DATA_W-1:0] o_dec_instr,
  output logic              o_branch_eq,
  output logic              o_branch_ne,
  output logic              o_memread,
  output logic              o_memwrite,
  output logic              o_memtoreg,
  output logic              o_regdst,
  output logic              o_regwrite,
  output logic              o_alusrc,
  output logic [1:0]        o_aluop,
  output logic              o_illegal
);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_drop;
  logic              r_imem_req;
  logic              r_dec_valid;
  logic [ADDR_W-1:0] r_dec_pc;
  logic [DATA_W-1:0] r_ir;
  ctrl_t             r_ctrl;

  ctrl_t             w_ctrl;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic [ADDR_W-1:0] w_pc_next;

  assign w_redirect_pc = i_redirect_pc & ~ADDR_W'(3);
  assign w_pc_next     = r_pc + ADDR_W'(PC_STEP);

  mips_ctrl_decode u_ctrl_decode (
    .i_opcode (i_imem_rdata[DATA_W-1 -: 6]),
    .o_ctrl   (w_ctrl)
  );

  // REQ only moves on once the request pulse has been presented, so the first
  // request after reset appears one cycle after release. r_drop marks a fetch
  // whose response must be swallowed because a redirect overtook it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_REQ;
      r_pc        <= RESET_PC;
      r_drop      <= 1'b0;
      r_imem_req  <= 1'b0;
      r_dec_valid <= 1'b0;
      r_dec_pc    <= '0;
      r_ir        <= '0;
      r_ctrl      <= CTRL_NONE;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (i_redirect) begin
            r_pc <= w_redirect_pc;
            if (r_imem_req) begin
              r_imem_req <= 1'b0;
              r_drop     <= 1'b1;
              r_state    <= ST_WAIT;
            end else begin
              r_imem_req <= 1'b1;
            end
          end else if (r_imem_req) begin
            r_imem_req <= 1'b0;
            r_state    <= ST_WAIT;
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (i_redirect) begin
            r_pc <= w_redirect_pc;
            if (i_imem_valid) begin
              r_drop     <= 1'b0;
              r_imem_req <= 1'b1;
              r_state    <= ST_REQ;
            end else begin
              r_drop <= 1'b1;
            end
          end else if (i_imem_valid) begin
            if (r_drop) begin
              r_drop     <= 1'b0;
              r_imem_req <= 1'b1;
              r_state    <= ST_REQ;
            end else begin
              r_ir        <= i_imem_rdata;
              r_dec_pc    <= r_pc;
              r_pc        <= w_pc_next;
              r_ctrl      <= w_ctrl;
              r_dec_valid <= 1'b1;
              r_state     <= ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (i_redirect) begin
            r_pc        <= w_redirect_pc;
            r_dec_valid <= 1'b0;
            r_imem_req  <= 1'b1;
            r_state     <= ST_REQ;
          end else if (!i_stall) begin
            r_dec_valid <= 1'b0;
            r_imem_req  <= 1'b1;
            r_state     <= ST_REQ;
          end
        end
        default: begin
          r_imem_req <= 1'b0;
          r_state    <= ST_REQ;
        end
      endcase
    end
  end

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_pc;
  assign o_dec_valid = r_dec_valid;
  assign o_dec_pc    = r_dec_pc;
  assign o_dec_instr = r_ir;
  assign o_regdst    = r_ctrl.regdst;
  assign o_alusrc    = r_ctrl.alusrc;
  assign o_memtoreg  = r_ctrl.memtoreg;
  assign o_regwrite  = r_ctrl.regwrite;
  assign o_memread   = r_ctrl.memread;
  assign o_memwrite  = r_ctrl.memwrite;
  assign o_branch_eq = r_ctrl.branch_eq;
  assign o_branch_ne = r_ctrl.branch_ne;
  assign o_aluop     = r_ctrl.aluop;
  assign o_illegal   = r_ctrl.illegal;

endmodule

// File: tb/tb_mips_fetch_decode.sv
// Bench for mips_fetch_decode: a table of instructions with varying memory latency,
// plus hand sequences for stall, redirect, PC wrap and mid-fetch reset.
module tb_mips_fetch_decode;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [10:0] ctrl;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    int          latency;
    logic [10:0] ctrl;
  } vec_t;

  // Control bundle order: regdst,alusrc,memtoreg,regwrite,memread,memwrite,beq,bne,aluop[1:0],illegal
  localparam logic [10:0] CTRL_R    = 11'b10010000100;
  localparam logic [10:0] CTRL_LW   = 11'b01111000000;
  localparam logic [10:0] CTRL_SW   = 11'b01000100000;
  localparam logic [10:0] CTRL_BEQ  = 11'b00000010010;
  localparam logic [10:0] CTRL_BNE  = 11'b00000001010;
  localparam logic [10:0] CTRL_ADDI = 11'b01010000000;
  localparam logic [10:0] CTRL_ILL  = 11'b00000000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid = 1'b0;
  logic [31:0] imemRdata = 32'h0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectPc = 32'h0;
  logic        decValid;
  logic [31:0] decPc;
  logic [31:0] decInstr;
  logic        branchEq, branchNe, memread, memwrite, memtoreg, regdst, regwrite, alusrc;
  logic [1:0]  aluop;
  logic        illegal;
  logic [10:0] ctrlBus;

  exp_t        scoreQ[$];
  logic [31:0] expPc;
  int          checks = 0;
  int          failures = 0;
  vec_t        vecs[6];

  assign ctrlBus = {regdst, alusrc, memtoreg, regwrite, memread, memwrite,
                    branchEq, branchNe, aluop, illegal};

  always #5 clk = ~clk;

  mips_fetch_decode dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .o_imem_req    (imemReq),
    .o_imem_addr   (imemAddr),
    .i_imem_valid  (imemValid),
    .i_imem_rdata  (imemRdata),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirectPc),
    .o_dec_valid   (decValid),
    .o_dec_pc      (decPc),
    .o_dec_instr   (decInstr),
    .o_branch_eq   (branchEq),
    .o_branch_ne   (branchNe),
    .o_memread     (memread),
    .o_memwrite    (memwrite),
    .o_memtoreg    (memtoreg),
    .o_regdst      (regdst),
    .o_regwrite    (regwrite),
    .o_alusrc      (alusrc),
    .o_aluop       (aluop),
    .o_illegal     (illegal)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitReq(output int waited);
    waited = 0;
    while (imemReq !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    if (imemReq !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL req_timeout: got imem_req=%b, expected 1 within 20 cycles", imemReq);
    end
  endtask

  // Answers the next fetch after `latency` cycles and queues the expected decode.
  task automatic applyStimulus(input logic [31:0] instr, input int latency,
                               input logic [10:0] ctrl, output int waited);
    exp_t e;
    waitReq(waited);
    checkOutput("imem_addr", imemAddr, expPc);
    e.pc    = expPc;
    e.instr = instr;
    e.ctrl  = ctrl;
    for (int i = 0; i < latency; i++) begin
      step();
      if (i == 0) checkOutput("req_pulse", 32'(imemReq), 32'd0);
    end
    checkOutput("dec_valid_early", 32'(decValid), 32'd0);
    imemValid = 1'b1;
    imemRdata = instr;
    scoreQ.push_back(e);
    expPc = expPc + 32'd4;
    step();
    imemValid = 1'b0;
    imemRdata = 32'hDEADBEEF;
  endtask

  task automatic popAndCompare();
    exp_t e;
    checkOutput("dec_valid", 32'(decValid), 32'd1);
    if (scoreQ.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard: got decode with empty queue, expected pending entry");
    end else begin
      e = scoreQ.pop_front();
      checkOutput("dec_pc", decPc, e.pc);
      checkOutput("dec_instr", decInstr, e.instr);
      checkOutput("controls", 32'(ctrlBus), 32'(e.ctrl));
    end
    checkOutput("next_pc", imemAddr, expPc);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    vecs[0] = '{32'h00221820, 5, CTRL_R};
    vecs[1] = '{32'hAC220008, 2, CTRL_SW};
    vecs[2] = '{32'h10220003, 3, CTRL_BEQ};
    vecs[3] = '{32'h14220003, 1, CTRL_BNE};
    vecs[4] = '{32'h20220005, 4, CTRL_ADDI};
    vecs[5] = '{32'h3C010001, 2, CTRL_ILL};

    repeat (3) step();
    checkOutput("rst_req", 32'(imemReq), 32'd0);
    checkOutput("rst_dec_valid", 32'(decValid), 32'd0);
    checkOutput("rst_addr", imemAddr, 32'h0);
    checkOutput("rst_ctrl", 32'(ctrlBus), 32'd0);
    checkOutput("rst_instr", decInstr, 32'h0);

    rst_n = 1'b1;
    expPc = 32'h0;
    applyStimulus(32'h8C220004, 1, CTRL_LW, waited);
    checkOutput("first_req_cycle", 32'(waited), 32'd1);
    popAndCompare();

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].instr, vecs[i].latency, vecs[i].ctrl, waited);
      popAndCompare();
    end

    // Stall holds the decode and suppresses the next request.
    applyStimulus(32'h20230007, 2, CTRL_ADDI, waited);
    stall = 1'b1;
    popAndCompare();
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("stall_valid", 32'(decValid), 32'd1);
      checkOutput("stall_req", 32'(imemReq), 32'd0);
      checkOutput("stall_instr", decInstr, 32'h20230007);
    end
    stall = 1'b0;

    // Redirect during WAIT: late response is swallowed, fetch resumes at 0x100.
    waitReq(waited);
    step();
    redirect   = 1'b1;
    redirectPc = 32'h00000103;
    step();
    redirect  = 1'b0;
    checkOutput("redir_wait_valid", 32'(decValid), 32'd0);
    imemValid = 1'b1;
    imemRdata = 32'h8C220004;
    expPc     = 32'h00000100;
    step();
    imemValid = 1'b0;
    checkOutput("redir_drop_valid", 32'(decValid), 32'd0);
    applyStimulus(32'hAC220010, 1, CTRL_SW, waited);
    checkOutput("redir_req_ready", 32'(waited), 32'd0);
    popAndCompare();

    // Redirect coinciding with the response: data discarded.
    waitReq(waited);
    step();
    redirect   = 1'b1;
    redirectPc = 32'h00000200;
    imemValid  = 1'b1;
    imemRdata  = 32'h10220003;
    step();
    redirect  = 1'b0;
    imemValid = 1'b0;
    checkOutput("redir_same_valid", 32'(decValid), 32'd0);
    expPc = 32'h00000200;
    applyStimulus(32'h14220003, 3, CTRL_BNE, waited);
    popAndCompare();

    // Redirect in OUT to the top word, then the fetch wraps PC to 0.
    redirect   = 1'b1;
    redirectPc = 32'hFFFFFFFE;
    step();
    redirect = 1'b0;
    checkOutput("redir_out_valid", 32'(decValid), 32'd0);
    expPc = 32'hFFFFFFFC;
    applyStimulus(32'hFC000000, 2, CTRL_ILL, waited);
    popAndCompare();
    applyStimulus(32'h20220005, 1, CTRL_ADDI, waited);
    popAndCompare();

    // Reset while waiting on memory clears everything at once.
    waitReq(waited);
    step();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_req", 32'(imemReq), 32'd0);
    checkOutput("midrst_addr", imemAddr, 32'h0);
    checkOutput("midrst_ctrl", 32'(ctrlBus), 32'd0);
    checkOutput("midrst_instr", decInstr, 32'h0);
    repeat (2) step();
    rst_n = 1'b1;
    scoreQ.delete();
    expPc = 32'h0;
    applyStimulus(32'h00221820, 1, CTRL_R, waited);
    checkOutput("midrst_restart_cycle", 32'(waited), 32'd1);
    popAndCompare();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
